// File: rtl/parser_pkg.sv
// Shared definitions for the parser receive path.
// Holds the word width, the packet length limit and the arbiter states.
package parser_pkg;

    localparam int WORD_W = 32;

    // 2 header words + 10 data words
    localparam int PARSER_MAX_BEATS = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/parser_input_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
// Ports: req (request vector), last (previous grant),
//        idx (next grant), vld (some request is set).
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          vld
);

    logic [IW-1:0] cand;

    // Scan last+1 .. last+N so that the previous winner is
    // considered last; it still wins when it is alone.
    always_comb begin
        idx  = last;
        vld  = 1'b0;
        cand = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(last) + i) % N);
            if (!vld && req[cand]) begin
                idx = cand;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parser_input_arbiter.sv
// Packet-granular round-robin arbiter in front of the parser.
// Ports: src_* (NUM_SRC word streams), dataOut* (parser side),
//        grant_idx, busy, oversize_err, pkt_count (status).
module parser_input_arbiter
    import parser_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int MAX_BEATS = PARSER_MAX_BEATS,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*WORD_W-1:0]   src_data,
    input  logic [NUM_SRC-1:0]          src_val,
    input  logic [NUM_SRC-1:0]          src_last,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic [WORD_W-1:0]           dataOut,
    output logic                        dataOut_val,
    output logic                        dataOut_last,
    input  logic                        dataOut_ready,
    output logic [$clog2(NUM_SRC)-1:0]  grant_idx,
    output logic                        busy,
    output logic                        oversize_err,
    output logic [CNT_W-1:0]            pkt_count
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam logic [BW-1:0] CAP = BW'(MAX_BEATS - 1);

    arb_state_t state;
    arb_state_t nstate;

    logic [BW-1:0]     beats;
    logic [WORD_W-1:0] words [NUM_SRC];
    logic [WORD_W-1:0] g_data;
    logic              g_val;
    logic              g_last;
    logic              at_cap;
    logic              accept;
    logic              pkt_end;
    logic [GW-1:0]     pick_idx;
    logic              pick_vld;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
        assign words[k] = src_data[k*WORD_W +: WORD_W];
    end

    assign g_data  = words[grant_idx];
    assign g_val   = src_val[grant_idx];
    assign g_last  = src_last[grant_idx];
    assign at_cap  = (beats == CAP);
    assign accept  = (state == PASS) && g_val && dataOut_ready;
    // Either a real last or a forced cut closes the packet.
    assign pkt_end = accept && (g_last || at_cap);

    rr_pick #(
        .N  (NUM_SRC),
        .IW (GW)
    ) u_pick (
        .req  (src_val),
        .last (grant_idx),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Next-state logic
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: begin
                if (pick_vld) nstate = PASS;
            end
            PASS: begin
                if (accept && g_last)     nstate = IDLE;
                else if (accept && at_cap) nstate = DRAIN;
            end
            DRAIN: begin
                if (g_val && g_last) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    // Grant, beat counter and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_idx    <= GW'(NUM_SRC - 1);
            beats        <= '0;
            pkt_count    <= '0;
            oversize_err <= 1'b0;
        end else begin
            oversize_err <= pkt_end && !g_last;
            if (state == IDLE) begin
                beats <= '0;
                if (pick_vld) grant_idx <= pick_idx;
            end else if (pkt_end) begin
                beats     <= '0;
                pkt_count <= pkt_count + CNT_W'(1);
            end else if (accept) begin
                beats <= beats + BW'(1);
            end
        end
    end

    // Output logic
    always_comb begin
        src_ready    = '0;
        dataOut      = '0;
        dataOut_val  = 1'b0;
        dataOut_last = 1'b0;
        unique case (state)
            PASS: begin
                dataOut              = g_data;
                dataOut_val          = g_val;
                dataOut_last         = g_last || at_cap;
                src_ready[grant_idx] = dataOut_ready;
            end
            DRAIN: begin
                src_ready[grant_idx] = 1'b1;
            end
            default: begin
                src_ready = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_parser_input_arbiter.sv
// Scoreboard bench for parser_input_arbiter.
// Drivers feed per-source beat queues; a monitor checks forwarded beats.
module tb_parser_input_arbiter;

    localparam int NS = 4;

    logic              clk;
    logic              reset;
    logic [NS*32-1:0]  src_data;
    logic [NS-1:0]     src_val;
    logic [NS-1:0]     src_last;
    logic [NS-1:0]     src_ready;
    logic [31:0]       dataOut;
    logic              dataOut_val;
    logic              dataOut_last;
    logic              dataOut_ready;
    logic [1:0]        grant_idx;
    logic              busy;
    logic              oversize_err;
    logic [15:0]       pkt_count;

    parser_input_arbiter #(
        .NUM_SRC   (NS),
        .MAX_BEATS (12),
        .CNT_W     (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .src_data      (src_data),
        .src_val       (src_val),
        .src_last      (src_last),
        .src_ready     (src_ready),
        .dataOut       (dataOut),
        .dataOut_val   (dataOut_val),
        .dataOut_last  (dataOut_last),
        .dataOut_ready (dataOut_ready),
        .grant_idx     (grant_idx),
        .busy          (busy),
        .oversize_err  (oversize_err),
        .pkt_count     (pkt_count)
    );

    typedef struct {
        logic [1:0]  src;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic [32:0] sq [NS][$];
    exp_t        exp_q [$];
    logic [NS-1:0] fire;
    logic        toggle;
    int          tests;
    int          fails;
    int          rx_cnt;
    int          ov_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Queue n beats on source s; the first ntx are expected at the parser.
    task automatic send(input int s, input int n, input int ntx);
        exp_t e;
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = 32'hA000_0000 | (s << 16) | (i + 1);
            sq[s].push_back({(i == n - 1), w});
            if (i < ntx) begin
                e.src  = 2'(s);
                e.data = w;
                e.last = (i == n - 1) || (i == 11);
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic bit all_empty();
        bit r;
        r = (exp_q.size() == 0);
        for (int k = 0; k < NS; k++) r = r && (sq[k].size() == 0);
        return r;
    endfunction

    task automatic wait_done(input string name, input int lim);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = all_empty() && !busy;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: timeout, busy=%0b exp_left=%0d",
                     name, busy, exp_q.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Source and parser-ready driver
    initial begin
        src_data      = '0;
        src_val       = '0;
        src_last      = '0;
        dataOut_ready = 1'b1;
        forever begin
            @(negedge clk);
            fire = src_val & src_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < NS; k++) begin
                if (fire[k] && sq[k].size() > 0) void'(sq[k].pop_front());
                src_val[k]  = (sq[k].size() > 0);
                src_last[k] = src_val[k] ? sq[k][0][32] : 1'b0;
                src_data[k*32 +: 32] = src_val[k] ? sq[k][0][31:0] : 32'h0;
            end
            dataOut_ready = toggle ? ~dataOut_ready : 1'b1;
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (oversize_err) ov_cnt++;
                if (dataOut_val && exp_q.size() > 0)
                    chk("ready_mirror", 32'(src_ready),
                        32'(NS'(dataOut_ready) << exp_q[0].src));
                if (dataOut_val && dataOut_ready) begin
                    rx_cnt++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: got %0h expected none",
                                 dataOut);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", dataOut, e.data);
                        chk("beat_last", 32'(dataOut_last), 32'(e.last));
                        chk("beat_grant", 32'(grant_idx), 32'(e.src));
                    end
                end
            end
        end
    end

    initial begin
        int rx0;
        int ov0;
        tests  = 0;
        fails  = 0;
        rx_cnt = 0;
        ov_cnt = 0;
        toggle = 1'b0;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(src_ready), 32'h0);
        chk("rst_val", 32'(dataOut_val), 32'h0);
        chk("rst_last", 32'(dataOut_last), 32'h0);
        chk("rst_data", dataOut, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ovf", 32'(oversize_err), 32'h0);
        chk("rst_grant", 32'(grant_idx), 32'd3);
        chk("rst_cnt", 32'(pkt_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // single 3-beat packet from source 0, one bubble first
        @(negedge clk);
        #1;
        send(0, 3, 3);
        @(negedge clk);
        #1;
        chk("t1_bubble", 32'(dataOut_val), 32'd0);
        @(negedge clk);
        #1;
        chk("t1_first", 32'(dataOut_val), 32'd1);
        wait_done("t1_done", 50);
        chk("t1_cnt", 32'(pkt_count), 32'd1);
        chk("t1_grant", 32'(grant_idx), 32'd0);

        // three sources at once, two rounds
        do_reset();
        #1;
        send(0, 2, 2);
        send(1, 2, 2);
        send(2, 2, 2);
        send(0, 2, 2);
        send(1, 2, 2);
        send(2, 2, 2);
        wait_done("t2_done", 100);
        chk("t2_cnt", 32'(pkt_count), 32'd6);
        chk("t2_grant", 32'(grant_idx), 32'd2);

        // lone source 3 is granted, then re-granted from grant 3
        send(3, 1, 1);
        wait_done("t3a_done", 50);
        chk("t3a_grant", 32'(grant_idx), 32'd3);
        send(3, 2, 2);
        wait_done("t3b_done", 50);
        chk("t3b_grant", 32'(grant_idx), 32'd3);
        chk("t3_cnt", 32'(pkt_count), 32'd8);

        // ready toggling during a 4-beat packet from source 2
        rx0 = rx_cnt;
        toggle = 1'b1;
        send(2, 4, 4);
        wait_done("t4_done", 100);
        toggle = 1'b0;
        chk("t4_beats", 32'(rx_cnt - rx0), 32'd4);
        chk("t4_cnt", 32'(pkt_count), 32'd9);

        // 15-beat packet from source 1 is cut at 12
        @(negedge clk);
        #1;
        rx0 = rx_cnt;
        ov0 = ov_cnt;
        send(1, 15, 12);
        wait_done("t5_done", 100);
        chk("t5_beats", 32'(rx_cnt - rx0), 32'd12);
        chk("t5_ovf", 32'(ov_cnt - ov0), 32'd1);
        chk("t5_cnt", 32'(pkt_count), 32'd10);
        chk("t5_grant", 32'(grant_idx), 32'd1);

        // reset after the second beat of a 5-beat packet
        rx0 = rx_cnt;
        send(0, 5, 2);
        for (int i = 0; i < 50 && rx_cnt - rx0 < 2; i++) begin
            @(negedge clk);
            #1;
        end
        chk("t6_two_beats", 32'(rx_cnt - rx0), 32'd2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_val", 32'(dataOut_val), 32'd0);
        chk("t6_rst_ready", 32'(src_ready), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_cnt", 32'(pkt_count), 32'd0);
        chk("t6_rst_grant", 32'(grant_idx), 32'd3);
        for (int k = 0; k < NS; k++) sq[k].delete();
        chk("t6_exp_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        send(0, 1, 1);
        send(1, 1, 1);
        wait_done("t6_done", 50);
        chk("t6_cnt", 32'(pkt_count), 32'd2);
        chk("t6_grant", 32'(grant_idx), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
